pyramid_gen_avg: RTL and testbench



---
 rtl/pyr_pkg.sv | 16 +
 rtl/pyr_down2.sv | 112 +++++++++++
 rtl/pyramid_gen_avg.sv | 97 +++++++++
 tb/tb_pyramid_gen_avg.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pyr_pkg.sv
// rtl/pyr_pkg.sv - shared constants and helpers for the averaging pyramid generator
package pyr_pkg;

  // Legal range for the number of pyramid levels
  localparam int LEVELS_MIN = 1;
  localparam int LEVELS_MAX = 4;

  // Added before the divide-by-4 so the 2x2 average rounds to nearest
  localparam int RND_CONST = 2;

  // Width of the sum of four pixels: two extra carry bits
  function automatic int sum_w(input int pix_w);
    return pix_w + 2;
  endfunction

endpackage

// File: rtl/pyr_down2.sv
// rtl/pyr_down2.sv - one 2x2 rounded box-filter down-sampling stage
module pyr_down2
  import pyr_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int ROW_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_wen,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_sof,
  output logic             out_wen,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_sof
);

  localparam int CW = (ROW_W > 1) ? $clog2(ROW_W) : 1;
  localparam int BW = (ROW_W > 2) ? $clog2(ROW_W / 2) : 1;
  localparam int HW = PIX_W + 1;
  localparam int SW = sum_w(PIX_W);

  logic [CW-1:0]    col_q, col_d;
  logic             odd_row_q, odd_row_d;
  logic [PIX_W-1:0] pair_q, pair_d;
  logic             sof_pend_q, sof_pend_d;
  logic             out_wen_q, out_wen_d;
  logic [PIX_W-1:0] out_pix_q, out_pix_d;
  logic             out_sof_q, out_sof_d;

  logic [HW-1:0]    line_buf [0:(1<<BW)-1];
  logic             buf_we;
  logic [BW-1:0]    buf_idx;
  logic [HW-1:0]    hsum;
  logic [SW-1:0]    avg;
  logic [CW-1:0]    cur_col;
  logic             cur_odd;

  // Position tracking, pair latch, row-0 buffering and row-1 averaging
  always_comb begin
    col_d      = col_q;
    odd_row_d  = odd_row_q;
    pair_d     = pair_q;
    sof_pend_d = sof_pend_q;
    out_wen_d  = 1'b0;
    out_pix_d  = out_pix_q;
    out_sof_d  = 1'b0;
    buf_we     = 1'b0;
    // A start-of-frame pixel is always (0,0), whatever the counters say
    cur_col    = in_sof ? '0 : col_q;
    cur_odd    = in_sof ? 1'b0 : odd_row_q;
    buf_idx    = BW'(cur_col >> 1);
    hsum       = HW'(pair_q) + HW'(in_pix);
    avg        = SW'(line_buf[buf_idx]) + SW'(hsum) + SW'(RND_CONST);
    if (in_wen) begin
      if (in_sof) begin
        sof_pend_d = 1'b1;
      end
      if (!cur_col[0]) begin
        pair_d = in_pix;
      end else if (!cur_odd) begin
        buf_we = 1'b1;
      end else begin
        out_wen_d  = 1'b1;
        out_pix_d  = PIX_W'(avg >> 2);
        // The first output after a sof is the (row 1, col 1) block
        out_sof_d  = sof_pend_d;
        sof_pend_d = 1'b0;
      end
      if (cur_col == CW'(ROW_W - 1)) begin
        col_d     = '0;
        odd_row_d = ~cur_odd;
      end else begin
        col_d     = cur_col + 1'b1;
        odd_row_d = cur_odd;
      end
    end
  end

  // Stage state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q      <= '0;
      odd_row_q  <= 1'b0;
      pair_q     <= '0;
      sof_pend_q <= 1'b0;
      out_wen_q  <= 1'b0;
      out_pix_q  <= '0;
      out_sof_q  <= 1'b0;
    end else begin
      col_q      <= col_d;
      odd_row_q  <= odd_row_d;
      pair_q     <= pair_d;
      sof_pend_q <= sof_pend_d;
      out_wen_q  <= out_wen_d;
      out_pix_q  <= out_pix_d;
      out_sof_q  <= out_sof_d;
    end
  end

  // Horizontal pair sums of the even row; always written before the odd row reads them
  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_buf[buf_idx] <= hsum;
    end
  end

  assign out_wen = out_wen_q;
  assign out_pix = out_pix_q;
  assign out_sof = out_sof_q;

endmodule

// File: rtl/pyramid_gen_avg.sv
// rtl/pyramid_gen_avg.sv - multi-level averaging image pyramid write-stream generator
module pyramid_gen_avg
  import pyr_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int LEVELS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [PIX_W-1:0]        in_pixel,
  output logic [LEVELS*PIX_W-1:0] lvl_pix,
  output logic [LEVELS-1:0]       lvl_wen,
  output logic [LEVELS-1:0]       lvl_sof,
  output logic                    frame_done
);

  localparam int TOTAL = (IMG_W * IMG_H) >> (2 * (LEVELS - 1));
  localparam int NW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  if (LEVELS < LEVELS_MIN || LEVELS > LEVELS_MAX) begin : g_bad_levels
    $error("pyramid_gen_avg: LEVELS must be within 1..4");
  end

  logic             l0_wen_q, l0_wen_d;
  logic [PIX_W-1:0] l0_pix_q, l0_pix_d;
  logic             l0_sof_q, l0_sof_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic [NW-1:0]    cnt_base;

  logic             st_wen [LEVELS];
  logic [PIX_W-1:0] st_pix [LEVELS];
  logic             st_sof [LEVELS];

  assign st_wen[0] = l0_wen_q;
  assign st_pix[0] = l0_pix_q;
  assign st_sof[0] = l0_sof_q;

  for (genvar k = 1; k < LEVELS; k++) begin : g_stage
    pyr_down2 #(
      .PIX_W (PIX_W),
      .ROW_W (IMG_W >> (k - 1))
    ) u_down2 (
      .clk     (clk),
      .reset   (reset),
      .in_wen  (st_wen[k-1]),
      .in_pix  (st_pix[k-1]),
      .in_sof  (st_sof[k-1]),
      .out_wen (st_wen[k]),
      .out_pix (st_pix[k]),
      .out_sof (st_sof[k])
    );
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_out
    assign lvl_wen[k]                 = st_wen[k];
    assign lvl_sof[k]                 = st_sof[k];
    assign lvl_pix[k*PIX_W +: PIX_W]  = st_pix[k];
  end

  // Level-0 capture and the top-level write counter that marks frame end
  always_comb begin
    l0_wen_d   = in_valid;
    l0_pix_d   = in_valid ? in_pixel : l0_pix_q;
    l0_sof_d   = in_valid & in_sof;
    cnt_base   = st_sof[LEVELS-1] ? '0 : cnt_q;
    cnt_d      = cnt_q;
    frame_done = 1'b0;
    if (st_wen[LEVELS-1]) begin
      if (cnt_base == NW'(TOTAL - 1)) begin
        cnt_d      = '0;
        frame_done = 1'b1;
      end else begin
        cnt_d = cnt_base + 1'b1;
      end
    end
  end

  // Level-0 register stage and frame counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l0_wen_q <= 1'b0;
      l0_pix_q <= '0;
      l0_sof_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      l0_wen_q <= l0_wen_d;
      l0_pix_q <= l0_pix_d;
      l0_sof_q <= l0_sof_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pyramid_gen_avg.sv
// tb/tb_pyramid_gen_avg.sv - scoreboard bench for pyramid_gen_avg with an image-level golden model
module tb_pyramid_gen_avg;

  localparam int PW = 8;
  localparam int IW = 8;
  localparam int IH = 8;
  localparam int NL = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_sof;
  logic [PW-1:0]    in_pixel;
  logic [NL*PW-1:0] lvl_pix;
  logic [NL-1:0]    lvl_wen;
  logic [NL-1:0]    lvl_sof;
  logic             frame_done;
  logic [PW-1:0]    s_pix;
  logic [0:0]       s_wen;
  logic [0:0]       s_sof;
  logic             s_done;

  always #5 clk = ~clk;

  pyramid_gen_avg #(.PIX_W(PW), .IMG_W(IW), .IMG_H(IH), .LEVELS(NL)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .lvl_pix(lvl_pix), .lvl_wen(lvl_wen), .lvl_sof(lvl_sof), .frame_done(frame_done)
  );

  pyramid_gen_avg #(.PIX_W(PW), .IMG_W(IW), .IMG_H(IH), .LEVELS(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .lvl_pix(s_pix), .lvl_wen(s_wen), .lvl_sof(s_sof), .frame_done(s_done)
  );

  typedef struct {
    int pix;
    bit sof;
    bit done;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wcnt [NL];
  int img [0:IH-1][0:IW-1];
  int px13_cyc = -1;
  int l1_first_cyc = -1;
  int l1_first_pix = -1;
  int s_cnt = 0;
  int s_done_cnt = 0;
  int s_done_at = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_write(input int k, input int pix, input bit sof, input bit done);
    exp_t e;
    bit have;
    have = 1'b0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    n_cmp++;
    if (!have) begin
      n_bad++;
      $display("FAIL extra_write_lvl%0d: got pix=%0d sof=%0b, required no write", k, pix, sof);
    end else if (e.pix != pix || e.sof != sof || e.done != done) begin
      n_bad++;
      $display("FAIL write_lvl%0d: got pix=%0d sof=%0b done=%0b, required pix=%0d sof=%0b done=%0b",
               k, pix, sof, done, e.pix, e.sof, e.done);
    end
  endtask

  // Monitor: pop and compare every write the DUT presents
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NL; k++) begin
        if (lvl_wen[k]) begin
          wcnt[k]++;
          check_write(k, int'(lvl_pix[k*PW +: PW]), lvl_sof[k], (k == NL-1) ? frame_done : 1'b0);
        end
      end
      if (frame_done && !lvl_wen[NL-1]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL frame_done_alone: got frame_done=1 with no level-%0d write, required 0", NL-1);
      end
      if (lvl_wen[1] && l1_first_cyc < 0) begin
        l1_first_cyc = cyc;
        l1_first_pix = int'(lvl_pix[PW +: PW]);
      end
      if (s_wen[0]) begin
        s_cnt = s_sof[0] ? 1 : s_cnt + 1;
        if (s_done) begin
          s_done_cnt++;
          s_done_at = s_cnt;
        end
      end
    end
  end

  // Golden model: full pyramid of img, pushing only entries whose source pixels were delivered
  task automatic push_expected(input int n);
    int p1 [0:3][0:3];
    bit m1 [0:3][0:3];
    int p2;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '{pix: img[i/IW][i%IW], sof: (i == 0), done: 1'b0};
      q0.push_back(e);
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        p1[r][c] = (img[2*r][2*c] + img[2*r][2*c+1] + img[2*r+1][2*c] + img[2*r+1][2*c+1] + 2) >> 2;
        m1[r][c] = (((2*r+1)*IW + 2*c+1) < n);
        if (m1[r][c]) begin
          e = '{pix: p1[r][c], sof: (r == 0 && c == 0), done: 1'b0};
          q1.push_back(e);
        end
      end
    end
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        p2 = (p1[2*r][2*c] + p1[2*r][2*c+1] + p1[2*r+1][2*c] + p1[2*r+1][2*c+1] + 2) >> 2;
        if (m1[2*r+1][2*c+1]) begin
          e = '{pix: p2, sof: (r == 0 && c == 0), done: (r == 1 && c == 1)};
          q2.push_back(e);
        end
      end
    end
  endtask

  task automatic send_frame(input int n, input bit gaps);
    push_expected(n);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 2)) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_sof   = (i == 0);
      in_pixel = PW'(img[i/IW][i%IW]);
      if (i == IW + 1) px13_cyc = cyc;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic check_drained(input string name);
    check_int(name, q0.size() + q1.size() + q2.size(), 0);
  endtask

  task automatic check_counts(input string name, input int c0, input int c1, input int c2);
    check_int({name, "_lvl0_writes"}, wcnt[0], c0);
    check_int({name, "_lvl1_writes"}, wcnt[1], c1);
    check_int({name, "_lvl2_writes"}, wcnt[2], c2);
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NL; k++) wcnt[k] = 0;
  endtask

  task automatic check_outputs_zero(input string name);
    check_int({name, "_lvl_pix"}, int'(lvl_pix), 0);
    check_int({name, "_lvl_wen"}, int'(lvl_wen), 0);
    check_int({name, "_lvl_sof"}, int'(lvl_sof), 0);
    check_int({name, "_frame_done"}, int'(frame_done), 0);
    check_int({name, "_l1_pix"}, int'(s_pix), 0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = '0;
    clear_counts();
    idle(3);
    check_outputs_zero("reset");
    reset = 1'b0;
    idle(2);

    // Flat 255 frame: every level stays 255, single-level instance ends on write 64
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = 255;
    clear_counts();
    send_frame(64, 1'b0);
    idle(6);
    check_counts("flat", 64, 16, 4);
    check_drained("flat_drained");
    check_int("l1inst_done_pulses", s_done_cnt, 1);
    check_int("l1inst_done_at_write", s_done_at, 64);
    check_int("l1inst_last_pix", int'(s_pix), 255);

    // First block 10,11 / 12,13 averages to 12, two cycles after pixel 13
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = ((r*IW + c) * 5) % 256;
    img[0][0] = 10; img[0][1] = 11; img[1][0] = 12; img[1][1] = 13;
    clear_counts();
    l1_first_cyc = -1;
    send_frame(64, 1'b0);
    idle(6);
    check_int("first_l1_pix", l1_first_pix, 12);
    check_int("first_l1_latency", l1_first_cyc - px13_cyc, 2);
    check_counts("block", 64, 16, 4);
    check_drained("block_drained");

    // Ramp with an idle cycle every third pixel
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = c + 8*r;
    clear_counts();
    send_frame(64, 1'b1);
    idle(6);
    check_counts("ramp_gaps", 64, 16, 4);
    check_drained("ramp_drained");

    // Frame cut at row 3 col 5 by a new sof, followed by a complete frame
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = ((r*IW + c) * 3) % 256;
    clear_counts();
    send_frame(3*IW + 5, 1'b0);
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = 255 - (c + 8*r);
    send_frame(64, 1'b0);
    idle(6);
    check_counts("resync", 29 + 64, 6 + 16, 1 + 4);
    check_drained("resync_drained");

    // Reset during row 2, then a clean frame
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = 100 + r + c;
    clear_counts();
    send_frame(2*IW + 4, 1'b0);
    idle(6);
    check_drained("pre_reset_drained");
    reset = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    idle(2);
    reset = 1'b0;
    idle(1);
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = (r * 37 + c * 11) % 256;
    send_frame(64, 1'b1);
    idle(6);
    check_counts("after_reset", 20 + 64, 4 + 16, 4);
    check_drained("after_reset_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
